// File: rtl/sq_energy_acc_if.sv
// ---------------------------------------------------------------------------
// sq_energy_acc_if
// Bundles the pixel input stream and the energy result stream of the
// sum-of-squares accumulator.
//   in_valid / in_ready / in_data / in_last        : pixel beat handshake
//   out_valid / out_ready / out_energy /
//   out_count / out_sat                            : per-frame result handshake
// Modports:
//   master : the side that produces pixels and consumes results
//   slave  : the accumulator itself
// ---------------------------------------------------------------------------
interface sq_energy_acc_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_energy;
  logic [CNT_W-1:0]  out_count;
  logic              out_sat;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_energy, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_energy, out_count, out_sat
  );
endinterface

// File: rtl/sq_energy_acc.sv
// ---------------------------------------------------------------------------
// sq_energy_acc
// Streaming sum-of-squares accumulator. Each accepted pixel is squared in a
// registered stage 1, stage 2 adds the square into a saturating accumulator
// and bumps a saturating beat counter. When the beat flagged in_last has been
// added, the frame totals are copied to the output registers and held until
// the downstream (Sqrt radical path) takes them.
// Ports:
//   clk      : clock, rising edge
//   aclr     : asynchronous active-high reset
//   sync_clr : synchronous flush, drops the frame in flight and any result
//   bus      : sq_energy_acc_if.slave (pixel stream in, energy result out)
// Timing: last beat accepted at edge T -> out_valid high after edge T+2;
// in_ready returns the cycle after the result is consumed (no bypass).
// ---------------------------------------------------------------------------
module sq_energy_acc #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           aclr,
  input  logic           sync_clr,
  sq_energy_acc_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;

  logic                in_ready_r;
  logic                in_ready_nxt_s;
  logic                accept_s;
  logic                consume_s;
  logic                out_load_s;
  logic                frame_clr_s;

  logic [2*DATA_W-1:0] sq_r;
  logic                s1_valid_r;
  logic                s1_last_r;

  logic [ACC_W-1:0]    acc_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                sat_r;
  logic [ACC_W:0]      sum_s;
  logic [ACC_W-1:0]    acc_nxt_s;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic                sat_nxt_s;

  logic                out_valid_r;
  logic [ACC_W-1:0]    out_energy_r;
  logic [CNT_W-1:0]    out_count_r;
  logic                out_sat_r;

  assign accept_s  = bus.in_valid && in_ready_r;
  assign consume_s = out_valid_r && bus.out_ready;

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_energy = out_energy_r;
  assign bus.out_count  = out_count_r;
  assign bus.out_sat    = out_sat_r;

  // FSM state register
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_r <= ST_ACCUM;
    end else if (sync_clr) begin
      state_r <= ST_ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: DRAIN is entered on the edge where stage 2 adds the last square
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_ACCUM: begin
        if (s1_valid_r && s1_last_r) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_DRAIN: state_nxt_s = ST_HOLD;
      ST_HOLD: begin
        if (consume_s) begin
          state_nxt_s = ST_ACCUM;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: state_nxt_s = ST_ACCUM;
    endcase
  end

  // FSM outputs: in_ready drops right after the last beat is taken so the
  // window between stage 1 and DRAIN cannot swallow a beat of the next frame
  always_comb begin
    in_ready_nxt_s = 1'b0;
    out_load_s     = 1'b0;
    frame_clr_s    = 1'b0;
    case (state_r)
      ST_ACCUM: in_ready_nxt_s = !(accept_s && bus.in_last) && !(s1_valid_r && s1_last_r);
      ST_DRAIN: out_load_s = 1'b1;
      ST_HOLD: begin
        frame_clr_s    = consume_s;
        in_ready_nxt_s = consume_s;
      end
      default: in_ready_nxt_s = 1'b0;
    endcase
  end

  // Stage 1: square the accepted pixel
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      sq_r       <= {(2*DATA_W){1'b0}};
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
    end else if (sync_clr) begin
      sq_r       <= {(2*DATA_W){1'b0}};
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        sq_r      <= (2*DATA_W)'(bus.in_data) * (2*DATA_W)'(bus.in_data);
        s1_last_r <= bus.in_last;
      end else begin
        sq_r      <= sq_r;
        s1_last_r <= s1_last_r;
      end
    end
  end

  // Stage 2 arithmetic: saturating add and saturating beat count
  always_comb begin
    sum_s     = {1'b0, acc_r} + (ACC_W+1)'(sq_r);
    acc_nxt_s = acc_r;
    cnt_nxt_s = cnt_r;
    sat_nxt_s = sat_r;
    if (s1_valid_r) begin
      if (sum_s[ACC_W]) begin
        acc_nxt_s = {ACC_W{1'b1}};
        sat_nxt_s = 1'b1;
      end else begin
        acc_nxt_s = sum_s[ACC_W-1:0];
      end
      if (cnt_r == {CNT_W{1'b1}}) begin
        cnt_nxt_s = cnt_r;
        sat_nxt_s = 1'b1;
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end
    end else begin
      acc_nxt_s = acc_r;
      cnt_nxt_s = cnt_r;
    end
  end

  // Stage 2 registers: frame accumulators, cleared once the result is taken
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      acc_r <= {ACC_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
      sat_r <= 1'b0;
    end else if (sync_clr) begin
      acc_r <= {ACC_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
      sat_r <= 1'b0;
    end else if (frame_clr_s) begin
      acc_r <= {ACC_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
      sat_r <= 1'b0;
    end else begin
      acc_r <= acc_nxt_s;
      cnt_r <= cnt_nxt_s;
      sat_r <= sat_nxt_s;
    end
  end

  // Output registers: loaded leaving DRAIN, values kept after consumption
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      in_ready_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      out_energy_r <= {ACC_W{1'b0}};
      out_count_r  <= {CNT_W{1'b0}};
      out_sat_r    <= 1'b0;
    end else if (sync_clr) begin
      in_ready_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      out_energy_r <= {ACC_W{1'b0}};
      out_count_r  <= {CNT_W{1'b0}};
      out_sat_r    <= 1'b0;
    end else begin
      in_ready_r <= in_ready_nxt_s;
      if (out_load_s) begin
        out_valid_r  <= 1'b1;
        out_energy_r <= acc_r;
        out_count_r  <= cnt_r;
        out_sat_r    <= sat_r;
      end else if (consume_s) begin
        out_valid_r  <= 1'b0;
      end else begin
        out_valid_r  <= out_valid_r;
      end
    end
  end

endmodule

// File: tb/tb_sq_energy_acc.sv
// ---------------------------------------------------------------------------
// tb_sq_energy_acc
// Self-checking bench for sq_energy_acc. A default-width instance carries the
// table vectors, the reset/flush sequences and random frames; a narrow
// instance (ACC_W=16, CNT_W=2) exercises energy and counter saturation.
// Expected results come from a frame-level model: clamp(sum p^2), clamp(N).
// ---------------------------------------------------------------------------
module tb_sq_energy_acc;
  localparam int DW   = 8;
  localparam int AW   = 32;
  localparam int CW   = 16;
  localparam int AW_S = 16;
  localparam int CW_S = 2;

  logic clk = 1'b0;
  logic aclr;
  logic sync_clr;
  int   tests = 0;
  int   fails = 0;
  int   pix_q[$];

  always #5 clk = ~clk;

  sq_energy_acc_if #(.DATA_W(DW), .ACC_W(AW),   .CNT_W(CW))   m ();
  sq_energy_acc_if #(.DATA_W(DW), .ACC_W(AW_S), .CNT_W(CW_S)) s ();

  sq_energy_acc #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .aclr(aclr), .sync_clr(sync_clr), .bus(m)
  );

  sq_energy_acc #(.DATA_W(DW), .ACC_W(AW_S), .CNT_W(CW_S)) dut_s (
    .clk(clk), .aclr(aclr), .sync_clr(sync_clr), .bus(s)
  );

  typedef struct packed {
    logic [2:0]      n;
    logic [3:0][7:0] px;
    logic [3:0]      hold;
    logic [31:0]     e;
    logic [15:0]     c;
    logic            sat;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frame-level reference: saturated sum of squares and beat count.
  function automatic void model(input int aw, input int cw, output logic [63:0] e,
                                output logic [63:0] c, output logic sat);
    longint emax = (longint'(1) << aw) - 1;
    longint cmax = (longint'(1) << cw) - 1;
    longint sum  = 0;
    foreach (pix_q[i]) sum += longint'(pix_q[i]) * longint'(pix_q[i]);
    sat = (sum > emax) || (longint'(pix_q.size()) > cmax);
    e   = (sum > emax) ? emax : sum;
    c   = (longint'(pix_q.size()) > cmax) ? cmax : longint'(pix_q.size());
  endfunction

  // Send pix_q as one frame to the wide instance and check result timing and values.
  task automatic run_frame(input string name, input int hold, input bit gaps,
                           input logic [63:0] e_exp, input logic [63:0] c_exp, input logic s_exp);
    int idx = 0;
    int guard = 0;
    @(negedge clk);
    while (m.in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({name, " start_ready"}, m.in_ready, 1);
    guard = 0;
    while (idx < pix_q.size() && guard < 200) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        m.in_valid = 1'b0;
      end else begin
        m.in_valid = 1'b1;
        m.in_data  = DW'(pix_q[idx]);
        m.in_last  = (idx == pix_q.size() - 1);
        if (m.in_ready === 1'b1) idx++;
      end
      guard++;
      @(negedge clk);
    end
    // After edge T: junk offered while not ready must be ignored.
    m.in_valid = 1'b1;
    m.in_data  = DW'($urandom);
    m.in_last  = 1'($urandom);
    chk({name, " ready_T"}, m.in_ready, 0);
    chk({name, " valid_T"}, m.out_valid, 0);
    @(negedge clk);
    chk({name, " ready_T1"}, m.in_ready, 0);
    chk({name, " valid_T1"}, m.out_valid, 0);
    @(negedge clk);
    chk({name, " valid_T2"}, m.out_valid, 1);
    chk({name, " ready_T2"}, m.in_ready, 0);
    chk({name, " energy"}, m.out_energy, e_exp);
    chk({name, " count"}, m.out_count, c_exp);
    chk({name, " sat"}, m.out_sat, s_exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({name, " hold_valid"}, m.out_valid, 1);
      chk({name, " hold_energy"}, m.out_energy, e_exp);
      chk({name, " hold_ready"}, m.in_ready, 0);
    end
    m.out_ready = 1'b1;
    m.in_valid  = 1'b0;
    m.in_last   = 1'b0;
    @(negedge clk);
    m.out_ready = 1'b0;
    chk({name, " valid_after"}, m.out_valid, 0);
    chk({name, " ready_after"}, m.in_ready, 1);
    chk({name, " energy_kept"}, m.out_energy, e_exp);
  endtask

  // Send pix_q back-to-back to the narrow instance and check its result.
  task automatic run_small(input string name, input logic [63:0] e_exp,
                           input logic [63:0] c_exp, input logic s_exp);
    int idx = 0;
    int guard = 0;
    @(negedge clk);
    while (idx < pix_q.size() && guard < 100) begin
      s.in_valid = 1'b1;
      s.in_data  = DW'(pix_q[idx]);
      s.in_last  = (idx == pix_q.size() - 1);
      if (s.in_ready === 1'b1) idx++;
      guard++;
      @(negedge clk);
    end
    s.in_valid = 1'b0;
    s.in_last  = 1'b0;
    guard = 0;
    while (s.out_valid !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk({name, " latency"}, guard, 2);
    chk({name, " energy"}, s.out_energy, e_exp);
    chk({name, " count"}, s.out_count, c_exp);
    chk({name, " sat"}, s.out_sat, s_exp);
    s.out_ready = 1'b1;
    @(negedge clk);
    s.out_ready = 1'b0;
    chk({name, " valid_after"}, s.out_valid, 0);
  endtask

  initial begin
    logic [63:0] e_m;
    logic [63:0] c_m;
    logic        s_m;

    vt[0] = '{3'd4, {8'd4, 8'd3, 8'd2, 8'd1},     4'd0, 32'd30,    16'd4, 1'b0};
    vt[1] = '{3'd1, {8'd0, 8'd0, 8'd0, 8'd255},   4'd0, 32'd65025, 16'd1, 1'b0};
    vt[2] = '{3'd2, {8'd0, 8'd0, 8'd20, 8'd10},   4'd5, 32'd500,   16'd2, 1'b0};
    vt[3] = '{3'd1, {8'd0, 8'd0, 8'd0, 8'd3},     4'd0, 32'd9,     16'd1, 1'b0};
    vt[4] = '{3'd4, {8'd1, 8'd0, 8'd255, 8'd0},   4'd1, 32'd65026, 16'd4, 1'b0};

    aclr = 1'b1;
    sync_clr = 1'b0;
    m.in_valid = 1'b0; m.in_data = '0; m.in_last = 1'b0; m.out_ready = 1'b0;
    s.in_valid = 1'b0; s.in_data = '0; s.in_last = 1'b0; s.out_ready = 1'b0;

    @(negedge clk);
    chk("rst out_valid", m.out_valid, 0);
    chk("rst out_energy", m.out_energy, 0);
    chk("rst out_count", m.out_count, 0);
    chk("rst out_sat", m.out_sat, 0);
    chk("rst in_ready", m.in_ready, 0);
    aclr = 1'b0;
    @(negedge clk);
    chk("rst in_ready_after", m.in_ready, 1);

    for (int i = 0; i < 5; i++) begin
      pix_q.delete();
      for (int j = 0; j < int'(vt[i].n); j++) pix_q.push_back(int'(vt[i].px[j]));
      run_frame($sformatf("vec%0d", i), int'(vt[i].hold), 1'b0, vt[i].e, vt[i].c, vt[i].sat);
    end

    // aclr part-way through a frame: partial sum dropped, no result.
    for (int j = 0; j < 3; j++) begin
      m.in_valid = 1'b1; m.in_data = 8'd9; m.in_last = 1'b0;
      @(negedge clk);
    end
    m.in_valid = 1'b0;
    aclr = 1'b1;
    #1;
    chk("aclr in_ready", m.in_ready, 0);
    chk("aclr out_energy", m.out_energy, 0);
    @(negedge clk);
    aclr = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("aclr no_valid", m.out_valid, 0);
    end
    pix_q = '{5};
    run_frame("after_aclr", 0, 1'b0, 25, 1, 1'b0);

    // sync_clr on the same edge as the last-beat acceptance.
    m.in_valid = 1'b1; m.in_data = 8'd7; m.in_last = 1'b0;
    @(negedge clk);
    m.in_data = 8'd7; m.in_last = 1'b1; sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0; m.in_valid = 1'b0; m.in_last = 1'b0;
    chk("sclr out_valid", m.out_valid, 0);
    chk("sclr out_energy", m.out_energy, 0);
    chk("sclr in_ready", m.in_ready, 0);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("sclr no_valid", m.out_valid, 0);
    end
    pix_q = '{6, 8};
    run_frame("after_sclr", 0, 1'b0, 100, 2, 1'b0);

    // Random frames with input gaps and random output backpressure.
    for (int k = 0; k < 25; k++) begin
      int n;
      n = $urandom_range(1, 12);
      pix_q.delete();
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 3) == 0) pix_q.push_back(255);
        else pix_q.push_back($urandom_range(0, 255));
      end
      model(AW, CW, e_m, c_m, s_m);
      run_frame($sformatf("rand%0d", k), $urandom_range(0, 3), 1'b1, e_m, c_m, s_m);
    end

    // Narrow instance: energy saturation, recovery, counter saturation.
    pix_q = '{255, 255};
    run_small("sat_energy", 64'hFFFF, 2, 1'b1);
    pix_q = '{2};
    run_small("sat_clear", 4, 1, 1'b0);
    pix_q = '{1, 1, 1};
    model(AW_S, CW_S, e_m, c_m, s_m);
    run_small("cnt_full", e_m, c_m, s_m);
    pix_q = '{1, 1, 1, 1};
    model(AW_S, CW_S, e_m, c_m, s_m);
    run_small("cnt_sat", e_m, c_m, s_m);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
